// File: rtl/vixen_video_pkg.sv
// Shared types and widths for the video fetch path.
package vixen_video_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;
  localparam int VID_ADDR_W = 16;
  localparam int VID_DATA_W = 8;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous register-array FIFO; flush wins over push and pop, dout reads 0 when empty.
module fetch_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (count != (AW+1)'(DEPTH));
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/video_fetch.sv
// Scanline byte fetcher: reads one line from the video port into a FIFO for the pixel shifter.
// Optional VIDEO_FETCH_STATS_EN adds a saturating underrun_count output.
module video_fetch
  import vixen_video_pkg::*;
#(
  parameter int BYTES_PER_LINE = 80,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  line_start,
  input  logic [VID_ADDR_W-1:0] line_base,
  output logic                  mem_en,
  output logic [VID_ADDR_W-1:0] mem_addr,
  input  logic [VID_DATA_W-1:0] mem_data,
  input  logic                  pix_req,
  output logic [VID_DATA_W-1:0] pix_data,
  output logic                  pix_valid,
  output logic                  busy,
`ifdef VIDEO_FETCH_STATS_EN
  output logic [7:0]            underrun_count,
`endif
  output logic                  underrun
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t          state_q, state_d;
  logic [VID_ADDR_W-1:0] next_addr;
  logic [7:0]            remaining;
  logic                  ret_q;
  logic                  issue;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           occupancy;
  logic                  empty_pop;

  // Occupancy counts both outstanding reads so the FIFO can never be overrun.
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(mem_en) + (CW+1)'(ret_q);
  assign busy      = (state_q != IDLE);
  assign pix_valid = ~fifo_empty;
  assign empty_pop = pix_req & fifo_empty;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE:  ;
      FETCH: begin
        issue = (remaining != 8'd0) && (occupancy < (CW+1)'(FIFO_DEPTH));
        if (issue && remaining == 8'd1) state_d = DRAIN;
      end
      DRAIN: if (!mem_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (line_start) begin
      state_d = FETCH;
      issue   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      next_addr <= '0;
      remaining <= '0;
      ret_q     <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      mem_en <= issue;
      // A read still in flight across line_start belongs to the old line.
      ret_q  <= mem_en & ~line_start;
      if (line_start) begin
        next_addr <= line_base;
        remaining <= 8'(BYTES_PER_LINE);
        underrun  <= 1'b0;
      end else begin
        if (issue) begin
          mem_addr  <= next_addr;
          next_addr <= next_addr + VID_ADDR_W'(1);
          remaining <= remaining - 8'd1;
        end
        if (empty_pop) underrun <= 1'b1;
      end
    end
  end

`ifdef VIDEO_FETCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   underrun_count <= 8'h00;
    else if (empty_pop && underrun_count != 8'hFF) underrun_count <= underrun_count + 8'd1;
  end
`endif

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(VID_DATA_W)) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (ret_q),
    .din   (mem_data),
    .pop   (pix_req),
    .flush (line_start),
    .dout  (pix_data),
    .count (fifo_count),
    .empty (fifo_empty)
  );
endmodule

// File: tb/tb_video_fetch.sv
// Bench for video_fetch: memory model, queue-based reference model checked every cycle, directed scenarios.
module tb_video_fetch;
  localparam int BPL = 80;
  localparam int FD  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        line_start;
  logic [15:0] line_base;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        pix_req;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        busy;
  logic        underrun;
`ifdef VIDEO_FETCH_STATS_EN
  logic [7:0]  underrun_count;
`endif

  // clock / reset block
  always #5 clk = ~clk;

  video_fetch #(.BYTES_PER_LINE(BPL), .FIFO_DEPTH(FD)) dut (
    .clk        (clk),
    .reset      (rst),
    .line_start (line_start),
    .line_base  (line_base),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .pix_req    (pix_req),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .busy       (busy),
`ifdef VIDEO_FETCH_STATS_EN
    .underrun_count (underrun_count),
`endif
    .underrun   (underrun)
  );

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    logic [7:0] lo, hi;
    lo = a[7:0];
    hi = a[15:8];
    return lo + hi * 8'd3 + 8'h5C;
  endfunction

  // memory: data the cycle after mem_en, junk otherwise
  always @(posedge clk) mem_data <= mem_en ? mem_byte(mem_addr) : 8'($urandom);

  int n_pass = 0;
  int n_total = 0;
  int cyc_n = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  always @(posedge clk) cyc_n++;

  // scoreboard / reference model
  logic [7:0]  exp_q[$];
  logic        m_active, m_under, m_ret_v;
  logic [15:0] m_addr, m_ret_a;
  int          m_issued;
  logic [7:0]  m_stats;
  int          pops = 0;
  int          issues = 0;
  int          last_issue_cyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_active = 1'b0; m_under = 1'b0; m_ret_v = 1'b0;
      m_addr = '0; m_ret_a = '0; m_issued = 0; m_stats = 8'h00;
    end else begin
      chk("pix_valid", pix_valid, exp_q.size() != 0);
      chk("pix_data", pix_data, exp_q.size() != 0 ? exp_q[0] : 8'h00);
      chk("underrun", underrun, m_under);
`ifdef VIDEO_FETCH_STATS_EN
      chk("underrun_count", underrun_count, m_stats);
`endif
      if (mem_en) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("issue_legal", m_active && m_issued < BPL && (exp_q.size() + int'(m_ret_v)) < FD, 1);
        issues++;
        last_issue_cyc = cyc_n;
      end
      if (pix_req && pix_valid) pops++;
      if (pix_req && exp_q.size() == 0 && m_stats != 8'hFF) m_stats++;
      if (line_start) begin
        exp_q.delete();
        m_ret_v = 1'b0; m_addr = line_base; m_issued = 0; m_active = 1'b1; m_under = 1'b0;
      end else begin
        if (pix_req) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          else m_under = 1'b1;
        end
        if (m_ret_v) exp_q.push_back(mem_byte(m_ret_a));
        m_ret_v = mem_en;
        m_ret_a = mem_addr;
        if (mem_en) begin
          m_addr = m_addr + 16'd1;
          m_issued++;
        end
      end
    end
  end

  // driver tasks
  int pop_base = 0;
  int issue_base = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input logic [15:0] base);
    line_base  = base;
    line_start = 1'b1;
    cyc();
    line_start = 1'b0;
    pop_base   = pops;
    issue_base = issues;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int t;
    t = 0;
    while (busy && t < budget) begin
      cyc();
      t++;
    end
    chk({name, "_idle"}, busy, 1'b0);
  endtask

  logic [15:0] wrap_exp [4];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; line_start = 1'b0; line_base = '0; pix_req = 1'b0;
    repeat (2) cyc();
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_pix_valid", pix_valid, 1'b0);
    chk("rst_pix_data", pix_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    rst = 1'b0;
    cyc();

    // basic line with continuous pops
    pix_req = 1'b1;
    start_line(16'h1000);
    chk("basic_c0_mem_en", mem_en, 1'b0);
    cyc();
    chk("basic_c1_mem_en", mem_en, 1'b1);
    chk("basic_c1_addr", mem_addr, 16'h1000);
    cyc();
    chk("basic_c2_valid", pix_valid, 1'b0);
    cyc();
    chk("basic_c3_valid", pix_valid, 1'b1);
    chk("basic_c3_data", pix_data, 8'h8C);
    wait_idle("basic", 200);
    chk("basic_busy_after_return", (cyc_n - last_issue_cyc) >= 2, 1'b1);
    repeat (3) cyc();
    chk("basic_pops", pops - pop_base, BPL);
    chk("basic_issues", issues - issue_base, BPL);

    // back-pressure
    pix_req = 1'b0;
    start_line(16'h2000);
    repeat (40) cyc();
    chk("bp_issues_full", issues - issue_base, FD);
    chk("bp_mem_en_full", mem_en, 1'b0);
    chk("bp_busy_full", busy, 1'b1);
    pix_req = 1'b1;
    wait_idle("bp", 300);
    repeat (20) cyc();
    chk("bp_pops", pops - pop_base, BPL);
    chk("bp_issues", issues - issue_base, BPL);
    chk("bp_empty", pix_valid, 1'b0);

    // address wrap
    wrap_exp[0] = 16'hFFFE; wrap_exp[1] = 16'hFFFF; wrap_exp[2] = 16'h0000; wrap_exp[3] = 16'h0001;
    pix_req = 1'b1;
    start_line(16'hFFFE);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("wrap_mem_en", mem_en, 1'b1);
      chk("wrap_addr", mem_addr, wrap_exp[i]);
    end
    wait_idle("wrap", 200);
    repeat (3) cyc();
    chk("wrap_pops", pops - pop_base, BPL);

    // abort with a read in flight
    pix_req = 1'b0;
    start_line(16'h3000);
    repeat (5) cyc();
    chk("abort_inflight", mem_en, 1'b1);
    line_base  = 16'h4000;
    line_start = 1'b1;
    cyc();
    line_start = 1'b0;
    pop_base   = pops;
    issue_base = issues;
    chk("abort_c0_valid", pix_valid, 1'b0);
    chk("abort_c0_mem_en", mem_en, 1'b0);
    cyc();
    chk("abort_c1_mem_en", mem_en, 1'b1);
    chk("abort_c1_addr", mem_addr, 16'h4000);
    chk("abort_c1_valid", pix_valid, 1'b0);
    cyc();
    chk("abort_c2_valid", pix_valid, 1'b0);
    cyc();
    chk("abort_c3_valid", pix_valid, 1'b1);
    chk("abort_c3_data", pix_data, 8'h1C);
    pix_req = 1'b1;
    wait_idle("abort", 300);
    repeat (20) cyc();
    chk("abort_pops", pops - pop_base, BPL);

    // reset mid-fetch
    pix_req = 1'b0;
    start_line(16'h7000);
    repeat (3) cyc();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_mem_en", mem_en, 1'b0);
    chk("mid_rst_mem_addr", mem_addr, 16'h0000);
    chk("mid_rst_pix_valid", pix_valid, 1'b0);
    chk("mid_rst_pix_data", pix_data, 8'h00);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_underrun", underrun, 1'b0);
`ifdef VIDEO_FETCH_STATS_EN
    chk("mid_rst_count", underrun_count, 8'h00);
`endif
    repeat (2) cyc();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("post_rst_mem_en", mem_en, 1'b0);
      chk("post_rst_busy", busy, 1'b0);
    end

    // underrun
    start_line(16'h5000);
    pix_req = 1'b1;
    cyc();
    chk("ur_c1", underrun, 1'b1);
    cyc();
    pix_req = 1'b0;
    chk("ur_c2", underrun, 1'b1);
`ifdef VIDEO_FETCH_STATS_EN
    chk("ur_count2", underrun_count, 8'd2);
`endif
    repeat (5) cyc();
    chk("ur_held", underrun, 1'b1);
    chk("ur_held_valid", pix_valid, 1'b1);
    start_line(16'h6000);
    chk("ur_cleared", underrun, 1'b0);
    pix_req = 1'b1;
    wait_idle("ur", 300);
    repeat (20) cyc();
    chk("ur_pops", pops - pop_base, BPL);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
